// File: rtl/fpnew_req_scheduler.sv
// ---------------------------------------------------------------------------
// fpnew_req_scheduler: round-robin issue arbiter with per-requester in-flight limits
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpnew_req_scheduler #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned ResWidth       = 38,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic                          issue_valid_o,
  input  logic                          issue_ready_i,
  output logic [DataWidth-1:0]          issue_data_o,
  output logic [IdWidth-1:0]            issue_id_o,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic [IdWidth-1:0]            res_id_i,
  input  logic [ResWidth-1:0]           res_data_i,
  output logic [NumReq-1:0]             resp_valid_o,
  input  logic [NumReq-1:0]             resp_ready_i,
  output logic [ResWidth-1:0]           resp_data_o,
  input  logic                          flush_i,
  output logic                          busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [CntWidth-1:0] cnt_q [NumReq];
  logic [CntWidth-1:0] cnt_d [NumReq];
  logic [IdWidth-1:0]  ptr_q, ptr_d;
  logic                lock_q, lock_d;
  logic [IdWidth-1:0]  lock_id_q, lock_id_d;

  logic [NumReq-1:0]   eligible;
  logic                grant_valid;
  logic [IdWidth-1:0]  grant_id;
  logic                issue_hs;
  logic                res_id_ok;
  logic                res_sel_ready;
  logic                resp_hs;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
    end
  end

  // A stalled grant stays with its requester regardless of its credit count.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (lock_q) begin
      grant_valid = req_valid_i[lock_id_q];
      grant_id    = lock_id_q;
    end else begin
      for (int k = NumReq - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % int'(NumReq);
        if (eligible[idx]) begin
          grant_valid = 1'b1;
          grant_id    = IdWidth'(idx);
        end
      end
    end
  end

  always_comb begin
    issue_valid_o = grant_valid & ~flush_i & rst_ni;
    issue_id_o    = grant_id;
    issue_hs      = issue_valid_o & issue_ready_i;
    issue_data_o  = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = issue_hs && (grant_id == IdWidth'(i));
      if (grant_id == IdWidth'(i)) begin
        issue_data_o = req_data_i[i*DataWidth +: DataWidth];
      end
    end
  end

  // Tags outside the requester range are accepted and silently dropped.
  always_comb begin
    res_id_ok     = 1'b0;
    res_sel_ready = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      resp_valid_o[i] = res_valid_i && (res_id_i == IdWidth'(i)) && !flush_i;
      if (res_id_i == IdWidth'(i)) begin
        res_id_ok     = 1'b1;
        res_sel_ready = resp_ready_i[i];
      end
    end
    res_ready_o = flush_i | ~res_id_ok | res_sel_ready;
    resp_hs     = res_valid_i & res_id_ok & res_sel_ready & ~flush_i;
    resp_data_o = res_data_i;
  end

  always_comb begin
    logic inc;
    logic dec;
    inc       = 1'b0;
    dec       = 1'b0;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      ptr_d     = '0;
      lock_d    = 1'b0;
      lock_id_d = '0;
      for (int i = 0; i < NumReq; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      if (issue_hs) begin
        lock_d = 1'b0;
        ptr_d  = (grant_id == IdWidth'(NumReq - 1)) ? '0 : grant_id + IdWidth'(1);
      end else if (issue_valid_o) begin
        lock_d    = 1'b1;
        lock_id_d = grant_id;
      end
      for (int i = 0; i < NumReq; i++) begin
        inc = issue_hs && (grant_id == IdWidth'(i));
        dec = resp_hs && (res_id_i == IdWidth'(i)) && (cnt_q[i] != '0);
        if (inc && !dec) begin
          cnt_d[i] = cnt_q[i] + CntWidth'(1);
        end else if (dec && !inc) begin
          cnt_d[i] = cnt_q[i] - CntWidth'(1);
        end
      end
    end
  end

  always_comb begin
    busy_o = issue_valid_o;
    for (int i = 0; i < NumReq; i++) begin
      if (cnt_q[i] != '0) begin
        busy_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpnew_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fpnew_req_scheduler: cycle-table checks of arbitration, credits, lock, flush and reset
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpnew_req_scheduler;

  localparam logic [63:0] D1 = 64'hB1B1_0000_0000_B1B1;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_data;
  logic         issue_valid;
  logic         issue_ready;
  logic [63:0]  issue_data;
  logic         issue_id;
  logic         res_valid;
  logic         res_ready;
  logic         res_id;
  logic [37:0]  res_data;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [37:0]  resp_data;
  logic         flush;
  logic         busy;

  logic         d3_res_valid;
  logic         d3_res_ready;
  logic [1:0]   d3_res_id;
  logic [2:0]   d3_resp_valid;
  logic [2:0]   d3_resp_ready;
  logic [37:0]  d3_resp_data;
  logic [2:0]   d3_req_ready;
  logic         d3_issue_valid;
  logic [63:0]  d3_issue_data;
  logic [1:0]   d3_issue_id;
  logic         d3_busy;

  always #5 clk_i = ~clk_i;

  fpnew_req_scheduler u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .issue_valid_o(issue_valid),
    .issue_ready_i(issue_ready),
    .issue_data_o (issue_data),
    .issue_id_o   (issue_id),
    .res_valid_i  (res_valid),
    .res_ready_o  (res_ready),
    .res_id_i     (res_id),
    .res_data_i   (res_data),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .flush_i      (flush),
    .busy_o       (busy)
  );

  fpnew_req_scheduler #(.NumReq(3)) u_dut3 (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (3'b000),
    .req_ready_o  (d3_req_ready),
    .req_data_i   (192'd0),
    .issue_valid_o(d3_issue_valid),
    .issue_ready_i(1'b0),
    .issue_data_o (d3_issue_data),
    .issue_id_o   (d3_issue_id),
    .res_valid_i  (d3_res_valid),
    .res_ready_o  (d3_res_ready),
    .res_id_i     (d3_res_id),
    .res_data_i   (res_data),
    .resp_valid_o (d3_resp_valid),
    .resp_ready_i (d3_resp_ready),
    .resp_data_o  (d3_resp_data),
    .flush_i      (1'b0),
    .busy_o       (d3_busy)
  );

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic       ir;
    logic       rv;
    logic       rid;
    logic [1:0] rr;
    logic       fl;
    logic       eiv;
    logic       eid;
    logic [1:0] erq;
    logic       errdy;
    logic [1:0] erv;
    logic       ebusy;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic add(input logic rst, input logic [1:0] v, input logic ir, input logic rv,
                     input logic rid, input logic [1:0] rr, input logic fl, input logic eiv,
                     input logic eid, input logic [1:0] erq, input logic errdy,
                     input logic [1:0] erv, input logic ebusy);
    vec_t r;
    r = '{rst, v, ir, rv, rid, rr, fl, eiv, eid, erq, errdy, erv, ebusy};
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_data;
    logic [63:0] rnd;
    rst_ni        = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    issue_ready   = 1'b0;
    res_valid     = 1'b0;
    res_id        = 1'b0;
    res_data      = '0;
    resp_ready    = '0;
    flush         = 1'b0;
    d3_res_valid  = 1'b0;
    d3_res_id     = '0;
    d3_resp_ready = '0;

    //   rst v     ir rv rid rr    fl | eiv eid erq   rrdy erv   busy
    add(0, 2'b11, 1, 1, 1, 2'b10, 0,   0,  0,  2'b00, 1,  2'b10, 0);
    add(0, 2'b00, 0, 0, 0, 2'b00, 0,   0,  0,  2'b00, 0,  2'b00, 0);
    add(1, 2'b00, 1, 0, 0, 2'b00, 0,   0,  0,  2'b00, 0,  2'b00, 0);
    for (int k = 0; k < 8; k++)
      add(1, 2'b11, 1, 0, 0, 2'b00, 0, 1, k[0], k[0] ? 2'b10 : 2'b01, 0, 2'b00, 1);
    add(1, 2'b11, 1, 0, 0, 2'b00, 0,   0,  0,  2'b00, 0,  2'b00, 1);
    // response frees a credit while the issue is blocked
    add(1, 2'b01, 1, 1, 0, 2'b01, 0,   0,  0,  2'b00, 1,  2'b01, 1);
    add(1, 2'b01, 1, 0, 0, 2'b00, 0,   1,  0,  2'b01, 0,  2'b00, 1);
    add(1, 2'b00, 1, 1, 1, 2'b10, 0,   0,  0,  2'b00, 1,  2'b10, 1);
    // simultaneous issue and response to requester 1 leaves its count at 3
    add(1, 2'b10, 1, 1, 1, 2'b10, 0,   1,  1,  2'b10, 1,  2'b10, 1);
    add(1, 2'b10, 1, 0, 0, 2'b00, 0,   1,  1,  2'b10, 0,  2'b00, 1);
    add(1, 2'b10, 1, 0, 0, 2'b00, 0,   0,  0,  2'b00, 0,  2'b00, 1);
    add(1, 2'b00, 1, 1, 0, 2'b01, 0,   0,  0,  2'b00, 1,  2'b01, 1);
    add(1, 2'b01, 1, 0, 0, 2'b00, 0,   1,  0,  2'b01, 0,  2'b00, 1);
    // flush with a pending result
    add(1, 2'b11, 1, 1, 0, 2'b00, 1,   0,  0,  2'b00, 1,  2'b00, 1);
    add(1, 2'b00, 1, 0, 0, 2'b00, 0,   0,  0,  2'b00, 0,  2'b00, 0);
    add(1, 2'b11, 1, 0, 0, 2'b00, 0,   1,  0,  2'b01, 0,  2'b00, 1);
    add(1, 2'b10, 1, 0, 0, 2'b00, 0,   1,  1,  2'b10, 0,  2'b00, 1);
    // stalled grant to 1 holds while 0 becomes the round-robin choice
    add(1, 2'b10, 0, 0, 0, 2'b00, 0,   1,  1,  2'b00, 0,  2'b00, 1);
    add(1, 2'b11, 0, 0, 0, 2'b00, 0,   1,  1,  2'b00, 0,  2'b00, 1);
    add(1, 2'b11, 0, 0, 0, 2'b00, 0,   1,  1,  2'b00, 0,  2'b00, 1);
    add(1, 2'b11, 1, 0, 0, 2'b00, 0,   1,  1,  2'b10, 0,  2'b00, 1);
    add(1, 2'b11, 1, 0, 0, 2'b00, 0,   1,  0,  2'b01, 0,  2'b00, 1);
    add(1, 2'b00, 1, 0, 0, 2'b00, 0,   0,  0,  2'b00, 0,  2'b00, 1);
    // reset in the middle of a stalled grant
    add(1, 2'b10, 0, 0, 0, 2'b00, 0,   1,  1,  2'b00, 0,  2'b00, 1);
    add(0, 2'b10, 0, 0, 0, 2'b00, 0,   0,  0,  2'b00, 0,  2'b00, 0);
    add(1, 2'b01, 1, 0, 0, 2'b00, 0,   1,  0,  2'b01, 0,  2'b00, 1);

    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk_i);
      #1;
      rst_ni      = tbl[r].rst;
      req_valid   = tbl[r].v;
      issue_ready = tbl[r].ir;
      res_valid   = tbl[r].rv;
      res_id      = tbl[r].rid;
      resp_ready  = tbl[r].rr;
      flush       = tbl[r].fl;
      req_data    = {D1, 32'hA0A0_A0A0, 32'(r)};
      rnd         = {$urandom(), $urandom()};
      res_data    = rnd[37:0];
      exp_data    = tbl[r].eid ? D1 : {32'hA0A0_A0A0, 32'(r)};
      if (tbl[r].eiv && tbl[r].ir) sb_q.push_back(exp_data);
      #2;
      chk($sformatf("row%0d issue_valid", r), 64'(issue_valid), 64'(tbl[r].eiv));
      chk($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(tbl[r].erq));
      chk($sformatf("row%0d res_ready", r), 64'(res_ready), 64'(tbl[r].errdy));
      chk($sformatf("row%0d resp_valid", r), 64'(resp_valid), 64'(tbl[r].erv));
      chk($sformatf("row%0d busy", r), 64'(busy), 64'(tbl[r].ebusy));
      chk($sformatf("row%0d resp_data", r), 64'(resp_data), 64'(res_data));
      if (tbl[r].eiv) begin
        chk($sformatf("row%0d issue_id", r), 64'(issue_id), 64'(tbl[r].eid));
        chk($sformatf("row%0d issue_data", r), issue_data, exp_data);
      end
      if (issue_valid && issue_ready) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("row%0d unexpected_issue", r), 64'd1, 64'd0);
        end else begin
          chk($sformatf("row%0d sb_issue_data", r), issue_data, sb_q.pop_front());
        end
      end
    end
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);

    // Out-of-range tag on a three-requester instance
    @(posedge clk_i);
    #1;
    req_valid     = '0;
    res_valid     = 1'b0;
    d3_res_valid  = 1'b1;
    d3_res_id     = 2'd3;
    d3_resp_ready = 3'b000;
    #2;
    chk("d3 drop res_ready", 64'(d3_res_ready), 64'd1);
    chk("d3 drop resp_valid", 64'(d3_resp_valid), 64'd0);
    @(posedge clk_i);
    #1;
    d3_res_valid = 1'b0;
    #2;
    chk("d3 drop busy", 64'(d3_busy), 64'd0);
    #1;
    d3_res_valid  = 1'b1;
    d3_res_id     = 2'd2;
    d3_resp_ready = 3'b100;
    #1;
    chk("d3 id2 res_ready", 64'(d3_res_ready), 64'd1);
    chk("d3 id2 resp_valid", 64'(d3_resp_valid), 64'h4);
    d3_resp_ready = 3'b011;
    #1;
    chk("d3 id2 stall res_ready", 64'(d3_res_ready), 64'd0);
    chk("d3 id2 stall resp_valid", 64'(d3_resp_valid), 64'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
